ssd_scan_ctrl: RTL and testbench
================================

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8: number of multiplexed digits, 1..16.
REQ-002 SHALL have parameter SCAN_DIV, default 14: log2 of clock cycles per digit slot, 2..20.
REQ-003 SHALL have parameter DEAD_CYC, default 4: anti-ghost cycles at the start of each slot; must be below 2**SCAN_DIV.
REQ-004 SHALL have parameter AN_ACTIVE_LOW, default 1: 1 means anodes are driven active-low.
REQ-005 SHALL have port Clk, input, 1 bit: the only clock.
REQ-006 SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port Load, input, 1 bit: one-cycle request to capture the display data.
REQ-008 SHALL have port Digits_in, input, 4*N_DIGITS bits: hex nibbles, digit k at [4k+3:4k].
REQ-009 SHALL have ports Dp_in and Blank_in, input, N_DIGITS bits each: per-digit dot-point lit and forced blank.
REQ-010 SHALL have port Load_ack, output, 1 bit: one-cycle pulse when shadow data goes live.
REQ-011 SHALL have port Frame_start, output, 1 bit: one-cycle pulse when the scan returns to digit 0.
REQ-012 SHALL have ports An (N_DIGITS bits), Seg (7 bits, {a..g}, active-low) and Dp (1 bit, active-low), all outputs and all registered.

Function
REQ-013 SHALL run a SCAN_DIV-bit prescaler every cycle; its wrap advances the digit index modulo N_DIGITS (N_DIGITS-1 to 0).
REQ-014 SHALL raise Frame_start on the cycle in which the digit index register becomes 0, including the first slot after reset.
REQ-015 SHALL, on Load, copy Digits_in, Dp_in and Blank_in into shadow registers and set a pending flag; a later Load before the boundary overwrites the shadow.
REQ-016 SHALL, at the frame boundary (the wrap from N_DIGITS-1 to 0) with pending set, copy shadow to active, clear pending and pulse Load_ack in that same cycle.
REQ-017 SHALL, when Load coincides with the boundary, promote the old shadow, then capture the new inputs with pending left set; with no prior pending, the new data waits one frame.
REQ-018 SHALL hold all anodes inactive while the prescaler is below DEAD_CYC; otherwise only An[index] is active, unless that digit is blanked.
REQ-019 SHALL hold Seg at 7'b1111111 and Dp at 1 for a blanked digit or during dead time.
REQ-020 SHALL decode hex to Seg as: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000.
REQ-021 SHALL register An, Seg and Dp from the current index, prescaler and active data, giving exactly one cycle of latency.
REQ-022 SHALL never display torn frames: active data changes only at the frame boundary.

Reset
REQ-023 SHALL, while Reset_n=0, force An inactive (all 1 when AN_ACTIVE_LOW=1), Seg=7'h7F, Dp=1, Load_ack=0 and Frame_start=0, immediately and asynchronously.
REQ-024 SHALL, while Reset_n=0, clear the prescaler, index, shadow, active and pending registers; a reset mid-frame discards any pending load.

Configuration
REQ-025 SHALL, with SSD_LZB_EN defined, blank every digit k>0 that is zero and has all higher digits zero (leading-zero blanking); digit 0 is never auto-blanked.
REQ-026 SHALL, without SSD_LZB_EN, blank digits only through Blank_in.
REQ-027 SHALL OR leading-zero blanking with Blank_in when both apply.

Structure
REQ-028 SHALL place the hex-to-segment table constant, the blank pattern constant and the parameter defaults in shared package ssd_pkg.
REQ-029 SHALL implement decoding in one combinational sub-module, ssd_hex_decoder (4-bit in, 7-bit out).

Verification (N_DIGITS=8, SCAN_DIV=4, DEAD_CYC=2, AN_ACTIVE_LOW=1)
REQ-030 SHALL cover reset: Reset_n=0 -> An=8'hFF, Seg=7'h7F, Dp=1; after release and dead time -> An=8'hFE with digit 0 shown.
REQ-031 SHALL cover a mid-frame load: Load with Digits_in=32'h1234ABCD at slot 3 -> old data until the boundary, then Load_ack pulse, then digit 0 Seg=1000010 and digit 7 Seg=1001111.
REQ-032 SHALL cover Load on the boundary cycle with no pending -> no Load_ack that frame; new data is live one frame later.
REQ-033 SHALL cover Blank_in=8'h0F -> An[3:0] never active and Seg=7'h7F during slots 0-3; Dp_in=8'h80 -> Dp=0 only in slot 7.
REQ-034 SHALL cover Reset_n pulsed low in slot 5 -> outputs inactive within the same cycle, index back to 0, pending cleared.
REQ-035 SHALL cover Digits_in=32'h000000A0: with SSD_LZB_EN, An[7:2] never active and digit 0 shows 0000001; without it, all 8 digits are shown.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller: segment table, blank
// pattern and parameter defaults.
package ssd_pkg;

  typedef logic [6:0] seg_t;

  localparam int N_DIGITS_DEF      = 8;
  localparam int SCAN_DIV_DEF      = 14;
  localparam int DEAD_CYC_DEF      = 4;
  localparam int AN_ACTIVE_LOW_DEF = 1;

  // Segments are {a,b,c,d,e,f,g}, active-low.
  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous double buffering.
// Define SSD_LZB_EN to add leading-zero blanking on top of Blank_in.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int N_DIGITS      = N_DIGITS_DEF,
  parameter int SCAN_DIV      = SCAN_DIV_DEF,
  parameter int DEAD_CYC      = DEAD_CYC_DEF,
  parameter int AN_ACTIVE_LOW = AN_ACTIVE_LOW_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Load,
  input  logic [4*N_DIGITS-1:0] Digits_in,
  input  logic [N_DIGITS-1:0]   Dp_in,
  input  logic [N_DIGITS-1:0]   Blank_in,
  output logic                  Load_ack,
  output logic                  Frame_start,
  output logic [N_DIGITS-1:0]   An,
  output logic [6:0]            Seg,
  output logic                  Dp
);

  localparam int                  IDX_W    = idx_width(N_DIGITS);
  localparam logic [SCAN_DIV-1:0] PRE_MAX  = '1;
  localparam logic [SCAN_DIV-1:0] PRE_DEAD = SCAN_DIV'(DEAD_CYC);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{AN_ACTIVE_LOW != 0}};

  logic                  running;
  logic [SCAN_DIV-1:0]   prescaler;
  logic [IDX_W-1:0]      index;

  logic [4*N_DIGITS-1:0] shadow_digits, act_digits;
  logic [N_DIGITS-1:0]   shadow_dp, act_dp;
  logic [N_DIGITS-1:0]   shadow_blank, act_blank;
  logic                  pending;

  logic                  wrap, boundary;
  logic                  dead, lzb, show;
  logic [3:0]            cur_digit;
  seg_t                  seg_dec;
  logic [N_DIGITS-1:0]   an_next;

  assign wrap      = running && (prescaler == PRE_MAX);
  assign boundary  = wrap && (index == IDX_LAST);
  assign dead      = prescaler < PRE_DEAD;
  assign cur_digit = act_digits[{index, 2'b00} +: 4];

`ifdef SSD_LZB_EN
  // A digit is a leading zero when it and every digit above it are zero.
  assign lzb = (index != '0) && ((act_digits >> {index, 2'b00}) == '0);
`else
  assign lzb = 1'b0;
`endif

  assign show = !dead && !(act_blank[index] || lzb);

  ssd_hex_decoder u_dec (
    .hex (cur_digit),
    .seg (seg_dec)
  );

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    an_next = AN_OFF;
    if (show) an_next[index] = (AN_ACTIVE_LOW == 0);
  end

  // The first edge after reset arms the scan; that cycle is the start of frame 0.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      running     <= 1'b0;
      prescaler   <= '0;
      index       <= '0;
      Frame_start <= 1'b0;
    end else begin
      running     <= 1'b1;
      Frame_start <= !running || boundary;
      if (running) begin
        prescaler <= prescaler + 1'b1;
        if (wrap) index <= (index == IDX_LAST) ? '0 : index + 1'b1;
      end
    end
  end

  // Shadow is promoted only at the frame boundary, so a frame is never torn.
  // NOTE: the data registers are reset as well, so a reset discards any pending load.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow_digits <= '0;
      shadow_dp     <= '0;
      shadow_blank  <= '0;
      act_digits    <= '0;
      act_dp        <= '0;
      act_blank     <= '0;
      pending       <= 1'b0;
      Load_ack      <= 1'b0;
    end else begin
      if (boundary && pending) begin
        act_digits <= shadow_digits;
        act_dp     <= shadow_dp;
        act_blank  <= shadow_blank;
      end
      if (Load) begin
        shadow_digits <= Digits_in;
        shadow_dp     <= Dp_in;
        shadow_blank  <= Blank_in;
      end
      pending  <= Load || (pending && !boundary);
      Load_ack <= boundary && pending;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      An  <= AN_OFF;
      Seg <= SEG_BLANK;
      Dp  <= 1'b1;
    end else begin
      An  <= an_next;
      Seg <= show ? seg_dec : SEG_BLANK;
      Dp  <= !(show && act_dp[index]);
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl: directed steps plus random loads, checked
// every cycle against a frame-level reference model (honours SSD_LZB_EN).
module tb_ssd_scan_ctrl;

  localparam int ND    = 8;
  localparam int SLOT  = 16;
  localparam int DC    = 2;
  localparam int FRAME = SLOT * ND;

  logic        Clk, Reset_n, Load;
  logic [31:0] Digits_in;
  logic [7:0]  Dp_in, Blank_in;
  logic        Load_ack, Frame_start;
  logic [7:0]  An;
  logic [6:0]  Seg;
  logic        Dp;

  int checks = 0;
  int errors = 0;

  // A load becomes visible from frame 'live' onward; the latest qualifying load wins.
  typedef struct {
    int unsigned live;
    logic [31:0] dig;
    logic [7:0]  dp;
    logic [7:0]  blk;
  } load_t;

  load_t       loads[$];
  int unsigned cyc;
  bit          in_rst;

  logic [6:0] seg_ref [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  ssd_scan_ctrl #(
    .N_DIGITS      (ND),
    .SCAN_DIV      (4),
    .DEAD_CYC      (DC),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Load        (Load),
    .Digits_in   (Digits_in),
    .Dp_in       (Dp_in),
    .Blank_in    (Blank_in),
    .Load_ack    (Load_ack),
    .Frame_start (Frame_start),
    .An          (An),
    .Seg         (Seg),
    .Dp          (Dp)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (cyc %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Scan position: cycle 0 after release is the arming cycle, both it and cycle 1 sit at 0.
  function automatic int unsigned pos_of(input int unsigned c);
    return (c == 0) ? 0 : c - 1;
  endfunction

  task automatic frame_data(input int unsigned f, output logic [31:0] d,
                            output logic [7:0] dp, output logic [7:0] blk);
    d = '0; dp = '0; blk = '0;
    foreach (loads[i]) if (loads[i].live <= f) begin
      d = loads[i].dig; dp = loads[i].dp; blk = loads[i].blk;
    end
  endtask

  task automatic check_outputs();
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_ack, e_fs, blank;
    logic [31:0] d;
    logic [7:0]  dp, blk;
    int unsigned s, k;
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_ack = 1'b0; e_fs = 1'b0;
    if (!in_rst && cyc >= 1) begin
      s = pos_of(cyc - 1);
      k = (s / SLOT) % ND;
      frame_data(s / FRAME, d, dp, blk);
      blank = blk[k];
`ifdef SSD_LZB_EN
      if (k > 0 && (d >> (4 * k)) == 0) blank = 1'b1;
`endif
      if ((s % SLOT) >= DC && !blank) begin
        e_an[k] = 1'b0;
        e_seg   = seg_ref[d[4*k +: 4]];
        e_dp    = ~dp[k];
      end
      e_fs = (pos_of(cyc) % FRAME) == 0;
      if (e_fs) foreach (loads[i]) if (loads[i].live == pos_of(cyc) / FRAME) e_ack = 1'b1;
    end
    check("an", An, e_an);
    check("seg", Seg, e_seg);
    check("dp", Dp, e_dp);
    check("load_ack", Load_ack, e_ack);
    check("frame_start", Frame_start, e_fs);
  endtask

  task automatic cycle();
    int unsigned p;
    if (Load && !in_rst) begin
      p = pos_of(cyc);
      loads.push_back('{live: ((p % FRAME) == FRAME - 1) ? p / FRAME + 2 : p / FRAME + 1,
                        dig: Digits_in, dp: Dp_in, blk: Blank_in});
    end
    @(posedge Clk);
    if (!in_rst) cyc++;
    @(negedge Clk);
    check_outputs();
  endtask

  task automatic run_until_pos(input int unsigned target);
    int n = 0;
    do begin cycle(); n++; end while ((pos_of(cyc) % FRAME) != target && n < 400);
    if ((pos_of(cyc) % FRAME) != target) begin
      checks++; errors++;
      $error("FAIL timeout_pos: observed %0d expected %0d", pos_of(cyc) % FRAME, target);
    end
  endtask

  task automatic run_until_out(input int unsigned slot, input int unsigned pre);
    int n = 0;
    int unsigned s;
    do begin
      cycle(); n++;
      s = (cyc >= 1) ? pos_of(cyc - 1) : 0;
    end while (!(cyc >= 1 && ((s / SLOT) % ND) == slot && (s % SLOT) == pre) && n < 400);
    if (!(((s / SLOT) % ND) == slot && (s % SLOT) == pre)) begin
      checks++; errors++;
      $error("FAIL timeout_out: observed slot %0d expected %0d", (s / SLOT) % ND, slot);
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] blk);
    Digits_in = d; Dp_in = dp; Blank_in = blk; Load = 1'b1;
    cycle();
    Load = 1'b0;
  endtask

  task automatic hold_reset();
    check("rst_an", An, 8'hFF);
    check("rst_seg", Seg, 7'h7F);
    check("rst_dp", Dp, 1'b1);
    check("rst_ack", Load_ack, 1'b0);
    check("rst_fs", Frame_start, 1'b0);
    in_rst = 1'b1;
    loads.delete();
    repeat (3) cycle();
    Reset_n = 1'b1;
    in_rst  = 1'b0;
    cyc     = 0;
  endtask

  initial begin
    Load = 1'b0; Digits_in = '0; Dp_in = '0; Blank_in = '0;
    cyc = 0; in_rst = 1'b1;
    Reset_n = 1'b1;
    #1 Reset_n = 1'b0;
    #1;
    hold_reset();

    // Power-up: digit 0 of all-zero data appears once the dead time has elapsed.
    run_until_out(0, 1);
    check("pu_dead_an", An, 8'hFF);
    run_until_out(0, 2);
    check("pu_an", An, 8'hFE);
    check("pu_seg", Seg, 7'b0000001);

    // Mid-frame load at slot 3: old data until the boundary, then ack and new data.
    run_until_pos(3 * SLOT + 5);
    do_load(32'h1234ABCD, 8'h00, 8'h00);
    run_until_pos(0);
    check("mid_fs", Frame_start, 1'b1);
    check("mid_ack", Load_ack, 1'b1);
    run_until_out(0, 8);
    check("mid_d0_an", An, 8'hFE);
    check("mid_d0_seg", Seg, 7'b1000010);
    run_until_out(7, 8);
    check("mid_d7_an", An, 8'h7F);
    check("mid_d7_seg", Seg, 7'b1001111);

    // Load on the boundary cycle with nothing pending waits a full frame.
    run_until_pos(FRAME - 1);
    do_load(32'h98765F0E, 8'h00, 8'h00);
    check("bnd_fs", Frame_start, 1'b1);
    check("bnd_ack_none", Load_ack, 1'b0);
    run_until_out(0, 8);
    check("bnd_old_seg", Seg, 7'b1000010);
    run_until_pos(0);
    check("bnd_ack_late", Load_ack, 1'b1);
    run_until_out(0, 8);
    check("bnd_new_seg", Seg, 7'b0110000);

    // Forced blanking of digits 0-3 and a single dot point on digit 7.
    run_until_pos(20);
    do_load($urandom | 32'h10000000, 8'h80, 8'h0F);
    run_until_pos(0);
    run_until_out(2, 8);
    check("blk_an", An, 8'hFF);
    check("blk_seg", Seg, 7'h7F);
    run_until_out(6, 8);
    check("dp6", Dp, 1'b1);
    run_until_out(7, 8);
    check("dp7", Dp, 1'b0);
    run_until_pos(0);

    // Random loads at random points, including some on the boundary cycle.
    repeat (12) begin
      int unsigned w;
      w = $urandom_range(1, 150);
      repeat (w) cycle();
      if ($urandom_range(0, 3) == 0) run_until_pos(FRAME - 1);
      do_load($urandom, 8'($urandom), ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00);
    end
    run_until_pos(0);
    run_until_pos(0);

    // Reset pulsed in slot 5 with a load pending: outputs drop at once, pending is lost.
    run_until_pos(2 * SLOT);
    do_load(32'h55555555, 8'hFF, 8'h00);
    run_until_pos(5 * SLOT + 7);
    #2 Reset_n = 1'b0;
    #1;
    hold_reset();
    run_until_pos(0);
    check("rr_fs", Frame_start, 1'b1);
    check("rr_ack", Load_ack, 1'b0);
    run_until_out(0, 2);
    check("rr_an", An, 8'hFE);
    check("rr_seg", Seg, 7'b0000001);
    run_until_pos(0);
    check("rr_no_ack", Load_ack, 1'b0);

    // Leading-zero blanking on 0x000000A0.
    run_until_pos(20);
    do_load(32'h000000A0, 8'h00, 8'h00);
    run_until_pos(0);
    run_until_out(5, 8);
`ifdef SSD_LZB_EN
    check("lzb_d5_an", An, 8'hFF);
`else
    check("lzb_d5_an", An, 8'hDF);
`endif
    run_until_out(0, 8);
    check("lzb_d0_an", An, 8'hFE);
    check("lzb_d0_seg", Seg, 7'b0000001);
    run_until_out(1, 8);
    check("lzb_d1_seg", Seg, 7'b0001000);
    run_until_pos(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
